qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- SPI/QSPI flash target (responder) that answers the SoC's qspi0 initiator (sck, cs, dq[3:0]) on the far side of the pads.
- Serves read commands from a byte-wide memory read port (BRAM image of the boot flash).
- Used for on-FPGA flash emulation and as the bench counterpart of the qspi0 controller.
- SPI mode 0: samples dq on rising sck, drives dq on falling sck; sck/cs are oversampled in the clkin1 domain.

Parameters:
- ADDR_W, 24, byte address width of the memory port and the command address field (24 bits fixed on the wire; upper bits beyond ADDR_W ignored).
- JEDEC_ID, 24'hEF4018, RDID response, sent MSB byte first.
- DUMMY_CYC, 8, dummy sck cycles for 0x0B/0x6B.
- SYNC_STAGES, 2, synchroniser depth for sck, cs, dq inputs (>=2).

Ports:
- clkin1  in  1  system clock; must be >= 8x sck frequency.
- globalrst  in  1  synchronous active-high reset.
- qspi_sck  in  1  serial clock from initiator.
- qspi_cs  in  1  chip select, active low.
- qspi_dq_i  in  4  pad input values (dq0=MOSI).
- qspi_dq_o  out  4  pad output values.
- qspi_dq_oe  out  4  per-bit output enable, 1=drive.
- mem_req  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  byte address, valid with mem_req.
- mem_rdata  in  8  read data, valid exactly 1 clkin1 after mem_req.
- busy  out  1  high while cs asserted and a transaction is in progress.
- cmd_err  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; counters/shift registers 0.
- Inputs pass through SYNC_STAGES flops. A further flop gives sck_rise/sck_fall/cs_fall/cs_rise single-cycle strobes.
- Synchronised cs high, at any state and any time: next cycle state=IDLE, qspi_dq_oe=0, busy=0. Any partial byte is discarded. Takes priority over simultaneous sck edges.
- IDLE: on cs_fall -> CMD, busy=1, bit counter=0.
- CMD: shift dq0 MSB-first on each sck_rise. After 8 bits, decode:
  - 0x03 READ -> ADDR.
  - 0x0B FAST_READ -> ADDR (dummy follows).
  - 0x6B QUAD_OUT_READ -> ADDR (dummy follows, quad data).
  - 0x9F RDID -> ID.
  - anything else -> cmd_err pulse (1 cycle), then IGNORE.
- ADDR: 24 bits on dq0, MSB-first. On the 24th sck_rise, latch the address. For 0x03, mem_req=1 with mem_addr=address in the same cycle and go to DATA. Otherwise go to DUMMY.
- DUMMY: count DUMMY_CYC sck_rise. On the last one, issue mem_req for the address and go to DATA.
- DATA:
  - mem_rdata is loaded into the out shift register 1 cycle after mem_req.
  - Each sck_fall shifts out MSB-first. Single mode: dq_o[1], dq_oe=4'b0010. Quad (0x6B): high nibble then low nibble on dq_o[3:0], dq_oe=4'b1111.
  - oe asserts on the first sck_fall after entering DATA.
  - When the last bit/nibble of a byte is shifted out, address+1 (wraps mod 2^ADDR_W) and mem_req is issued immediately, so the next byte is loaded before the next sck_fall.
  - Continues until cs rises.
- ID: JEDEC_ID bytes [23:16],[15:8],[7:0] on dq1 per sck_fall, MSB-first, repeating cyclically. No mem_req.
- IGNORE: dq_oe=0, no mem_req, wait for cs rise.
- dq_oe is 0 in IDLE, CMD, ADDR, DUMMY.
- New cs_fall in the same cycle as cs_rise-processed IDLE: handled on the next cycle (no lost command when cs is high for >= SYNC_STAGES+2 clkin1).
- mem_req is never asserted in two consecutive cycles.

Test Plan:
- 0x03, addr 0x000010, mem[0x10..0x13]=A5,3C,FF,00, 32 data sck -> mem_addr 0x10..0x13 in order; dq1 bitstream 10100101 00111100 11111111 00000000; oe=4'b0010 during data.
- 0x6B, addr 0x0000FF, 8 dummy, mem[0xFF]=0x9E, mem[0x100]=0x12 -> dq_o nibbles 9,E,1,2; dq_oe=4'hF; mem_addr 0xFF then 0x100.
- 0x03 at addr 0xFFFFFF (ADDR_W=24), 2 bytes -> mem_addr 0xFFFFFF then 0x000000.
- 0x9F, 32 data sck -> EF,40,18,EF on dq1; mem_req never asserted.
- Opcode 0x5A -> cmd_err single pulse; dq_oe stays 0 until cs high. Then 0x03 transaction works normally.
- cs deasserted mid-byte in 0x0B data phase -> dq_oe=0 and busy=0 within SYNC_STAGES+2 cycles. A following 0x9F returns EF first. globalrst asserted mid-transaction -> all outputs 0 next cycle.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// SPI/QSPI boot-flash responder: oversamples the initiator's sck/cs/dq and answers
// READ, FAST_READ, QUAD_OUT_READ and RDID from a byte-wide synchronous memory port.
module qspi_flash_responder #(
    parameter int unsigned ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int unsigned DUMMY_CYC   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clkin1,
    input  logic              globalrst,
    input  logic              qspi_sck,
    input  logic              qspi_cs,
    input  logic [3:0]        qspi_dq_i,
    output logic [3:0]        qspi_dq_o,
    output logic [3:0]        qspi_dq_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int unsigned CNT_MAX = (DUMMY_CYC > 24) ? DUMMY_CYC : 24;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_ID     = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] dq0_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   dq0;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   unused_dq_hi;

    logic [2:0]        state,    state_n;
    logic [CNT_W-1:0]  bit_cnt,  bit_cnt_n;
    logic [22:0]       shift_in, shift_n;
    logic              quad,     quad_n;
    logic              fast,     fast_n;
    logic [1:0]        id_idx,   id_idx_n;
    logic [7:0]        out_sr,   out_sr_n;
    logic [ADDR_W-1:0] addr,     addr_n;
    logic              rd_pend,  rd_pend_n;
    logic [3:0]        dq_o_n;
    logic [3:0]        dq_oe_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              busy_n;
    logic              cmd_err_n;

    logic [7:0]        opcode_rx;
    logic [ADDR_W-1:0] addr_rx;
    logic [ADDR_W-1:0] addr_inc;
    logic [1:0]        id_next;

    // Only dq0 carries initiator data; the upper lanes are output-only for this responder.
    assign unused_dq_hi = ^qspi_dq_i[3:1];

    always_ff @(posedge clkin1) begin
        if (globalrst) begin
            sck_sync <= '0;
            cs_sync  <= '0;
            dq0_sync <= '0;
            sck_d    <= 1'b0;
            cs_d     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], qspi_sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], qspi_cs};
            dq0_sync <= {dq0_sync[SYNC_STAGES-2:0], qspi_dq_i[0]};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign dq0      = dq0_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign opcode_rx = {shift_in[6:0], dq0};
    assign addr_rx   = ADDR_W'({shift_in, dq0});
    assign addr_inc  = addr + ADDR_W'(1);
    assign id_next   = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    endfunction

    always_ff @(posedge clkin1) begin
        if (globalrst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            quad       <= 1'b0;
            fast       <= 1'b0;
            id_idx     <= '0;
            out_sr     <= '0;
            addr       <= '0;
            rd_pend    <= 1'b0;
            qspi_dq_o  <= '0;
            qspi_dq_oe <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_in   <= shift_n;
            quad       <= quad_n;
            fast       <= fast_n;
            id_idx     <= id_idx_n;
            out_sr     <= out_sr_n;
            addr       <= addr_n;
            rd_pend    <= rd_pend_n;
            qspi_dq_o  <= dq_o_n;
            qspi_dq_oe <= dq_oe_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            busy       <= busy_n;
            cmd_err    <= cmd_err_n;
        end
    end

    // Next-state and registered-output logic; a deasserted cs overrides everything.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift_in;
        quad_n     = quad;
        fast_n     = fast;
        id_idx_n   = id_idx;
        out_sr_n   = out_sr;
        addr_n     = addr;
        rd_pend_n  = mem_req;
        dq_o_n     = qspi_dq_o;
        dq_oe_n    = qspi_dq_oe;
        mem_req_n  = 1'b0;
        mem_addr_n = mem_addr;
        busy_n     = busy;
        cmd_err_n  = 1'b0;

        if (cs_s) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            shift_n   = '0;
            rd_pend_n = 1'b0;
            dq_o_n    = '0;
            dq_oe_n   = '0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_n   = ST_CMD;
                        bit_cnt_n = '0;
                        busy_n    = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        shift_n = {shift_in[21:0], dq0};
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt_n = '0;
                            case (opcode_rx)
                                8'h03: begin
                                    state_n = ST_ADDR;
                                    quad_n  = 1'b0;
                                    fast_n  = 1'b0;
                                end
                                8'h0B: begin
                                    state_n = ST_ADDR;
                                    quad_n  = 1'b0;
                                    fast_n  = 1'b1;
                                end
                                8'h6B: begin
                                    state_n = ST_ADDR;
                                    quad_n  = 1'b1;
                                    fast_n  = 1'b1;
                                end
                                8'h9F: begin
                                    state_n  = ST_ID;
                                    id_idx_n = 2'd0;
                                    out_sr_n = id_byte(2'd0);
                                end
                                default: begin
                                    state_n   = ST_IGNORE;
                                    cmd_err_n = 1'b1;
                                end
                            endcase
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_n = {shift_in[21:0], dq0};
                        if (bit_cnt == CNT_W'(23)) begin
                            bit_cnt_n = '0;
                            addr_n    = addr_rx;
                            if (fast) begin
                                state_n = ST_DUMMY;
                            end else begin
                                state_n    = ST_DATA;
                                mem_req_n  = 1'b1;
                                mem_addr_n = addr_rx;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        if (bit_cnt == CNT_W'(DUMMY_CYC - 1)) begin
                            bit_cnt_n  = '0;
                            state_n    = ST_DATA;
                            mem_req_n  = 1'b1;
                            mem_addr_n = addr;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    // Last bit/nibble of a byte prefetches the next address well before the next fall.
                    if (sck_fall) begin
                        if (quad) begin
                            dq_o_n   = out_sr[7:4];
                            dq_oe_n  = 4'hF;
                            out_sr_n = {out_sr[3:0], 4'h0};
                        end else begin
                            dq_o_n   = {2'b00, out_sr[7], 1'b0};
                            dq_oe_n  = 4'b0010;
                            out_sr_n = {out_sr[6:0], 1'b0};
                        end
                        if (bit_cnt == (quad ? CNT_W'(1) : CNT_W'(7))) begin
                            bit_cnt_n  = '0;
                            addr_n     = addr_inc;
                            mem_req_n  = 1'b1;
                            mem_addr_n = addr_inc;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ID: begin
                    if (sck_fall) begin
                        dq_o_n  = {2'b00, out_sr[7], 1'b0};
                        dq_oe_n = 4'b0010;
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt_n = '0;
                            id_idx_n  = id_next;
                            out_sr_n  = id_byte(id_next);
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                            out_sr_n  = {out_sr[6:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: begin
                    dq_oe_n = '0;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
            if (rd_pend) begin
                out_sr_n = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: a mode-0 SPI initiator plus a BRAM model, with a
// transaction-level reference computing expected bits, nibbles and read addresses.
module tb_qspi_flash_responder;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DUMMY = 8;

    logic        clk;
    logic        globalrst;
    logic        qspi_sck;
    logic        qspi_cs;
    logic [3:0]  qspi_dq_i;
    logic [3:0]  qspi_dq_o;
    logic [3:0]  qspi_dq_oe;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        cmd_err;

    qspi_flash_responder #(
        .ADDR_W(24), .JEDEC_ID(24'hEF4018), .DUMMY_CYC(DUMMY), .SYNC_STAGES(SYNC)
    ) dut (
        .clkin1(clk), .globalrst(globalrst), .qspi_sck(qspi_sck), .qspi_cs(qspi_cs),
        .qspi_dq_i(qspi_dq_i), .qspi_dq_o(qspi_dq_o), .qspi_dq_oe(qspi_dq_oe),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash image: explicit bytes where loaded, otherwise a hash of the address.
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endfunction

    function automatic logic [7:0] jedec_byte(input int k);
        logic [23:0] id;
        id = 24'hEF4018;
        return id[23 - 8 * k -: 8];
    endfunction

    initial mem_rdata = 8'h00;
    always @(posedge clk) if (mem_req) mem_rdata <= mem_rd(mem_addr);

    // Expected read addresses, in order; the compare process consumes them.
    logic [23:0] exp_q [$];
    logic [23:0] seen_q [$];
    logic [3:0]  rx_q [$];
    int          exp_err_cnt = 0;
    int          err_seen = 0;
    logic        prev_req = 1'b0;
    logic        prev_err = 1'b0;
    logic [23:0] cmp_exp;
    int          hcyc = 4;

    always @(negedge clk) begin
        if (globalrst) begin
            prev_req = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (mem_req) begin
                check("mem_req back-to-back", 32'(prev_req), 32'(0));
                cmp_exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~mem_addr;
                check("mem_addr", 32'(mem_addr), 32'(cmp_exp));
                seen_q.push_back(mem_addr);
            end
            if (cmd_err) begin
                check("cmd_err pulse width", 32'(prev_err), 32'(0));
                err_seen++;
            end
            prev_req = mem_req;
            prev_err = cmd_err;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // One sck period: dq0 set while low, DUT output sampled at the rising edge, ends low.
    task automatic clk_bit(input logic b, output logic [3:0] dq_s, output logic [3:0] oe_s,
                           output logic busy_s);
        qspi_dq_i = {3'($urandom_range(0, 7)), b};
        repeat (hcyc) @(negedge clk);
        dq_s   = qspi_dq_o;
        oe_s   = qspi_dq_oe;
        busy_s = busy;
        qspi_sck = 1'b1;
        repeat (hcyc) @(negedge clk);
        qspi_sck = 1'b0;
    endtask

    task automatic cs_release();
        repeat (hcyc) @(negedge clk);
        qspi_cs = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        check("oe after cs high", 32'(qspi_dq_oe), 32'(0));
        check("busy after cs high", 32'(busy), 32'(0));
        check("outstanding mem_req", 32'(exp_q.size()), 32'(0));
        check("cmd_err count", 32'(err_seen), 32'(exp_err_cnt));
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int n_units,
                        input int rst_at);
        int         mode;
        int         dummy;
        int         upb;
        int         n_run;
        logic [3:0] dq_s;
        logic [3:0] oe_s;
        logic [3:0] exp_oe;
        logic [7:0] byte_v;
        logic       busy_s;
        hcyc = $urandom_range(4, 6);
        rx_q.delete();
        seen_q.delete();
        err_seen = 0;
        case (op)
            8'h03, 8'h0B: mode = 0;
            8'h6B:        mode = 1;
            8'h9F:        mode = 2;
            default:      mode = 3;
        endcase
        dummy       = (op == 8'h0B || op == 8'h6B) ? DUMMY : 0;
        n_run       = (rst_at >= 0) ? rst_at : n_units;
        exp_err_cnt = (mode == 3) ? 1 : 0;
        exp_oe      = (mode == 1) ? 4'hF : (mode == 3) ? 4'h0 : 4'b0010;
        if (mode <= 1) begin
            upb = (mode == 1) ? 2 : 8;
            for (int i = 0; i <= (n_run + 1) / upb; i++) exp_q.push_back(addr + 24'(i));
        end
        qspi_cs = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(op[i], dq_s, oe_s, busy_s);
            check("oe in opcode", 32'(oe_s), 32'(0));
            check("busy in opcode", 32'(busy_s), 32'(1));
        end
        if (mode <= 1) begin
            for (int i = 23; i >= 0; i--) begin
                clk_bit(addr[i], dq_s, oe_s, busy_s);
                check("oe in address", 32'(oe_s), 32'(0));
            end
        end
        for (int i = 0; i < dummy; i++) begin
            clk_bit(1'($urandom_range(0, 1)), dq_s, oe_s, busy_s);
            check("oe in dummy", 32'(oe_s), 32'(0));
        end
        for (int i = 0; i < n_run; i++) begin
            clk_bit(1'($urandom_range(0, 1)), dq_s, oe_s, busy_s);
            check("oe in data", 32'(oe_s), 32'(exp_oe));
            check("busy in data", 32'(busy_s), 32'(1));
            case (mode)
                0: begin
                    byte_v = mem_rd(addr + 24'(i / 8));
                    check("dq1 read bit", 32'(dq_s[1]), 32'((byte_v >> (7 - i % 8)) & 8'h01));
                    rx_q.push_back({3'b000, dq_s[1]});
                end
                1: begin
                    byte_v = mem_rd(addr + 24'(i / 2));
                    check("quad nibble", 32'(dq_s), 32'((i % 2 == 0) ? byte_v[7:4] : byte_v[3:0]));
                    rx_q.push_back(dq_s);
                end
                2: begin
                    byte_v = jedec_byte((i / 8) % 3);
                    check("dq1 id bit", 32'(dq_s[1]), 32'((byte_v >> (7 - i % 8)) & 8'h01));
                    rx_q.push_back({3'b000, dq_s[1]});
                end
                default: ;
            endcase
        end
        if (rst_at >= 0) begin
            repeat (hcyc) @(negedge clk);
            globalrst = 1'b1;
            @(negedge clk);
            check("rst dq_o", 32'(qspi_dq_o), 32'(0));
            check("rst dq_oe", 32'(qspi_dq_oe), 32'(0));
            check("rst mem_req", 32'(mem_req), 32'(0));
            check("rst mem_addr", 32'(mem_addr), 32'(0));
            check("rst busy", 32'(busy), 32'(0));
            check("rst cmd_err", 32'(cmd_err), 32'(0));
            globalrst = 1'b0;
        end
        cs_release();
    endtask

    function automatic logic [7:0] rx_byte(input int k);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], rx_q[8 * k + j][0]};
        return b;
    endfunction

    logic [7:0] lit_rd [4];
    logic [7:0] lit_id [4];
    logic [3:0] lit_nb [4];
    logic [7:0] op;
    logic [23:0] ra;

    initial begin
        globalrst = 1'b1;
        qspi_sck  = 1'b0;
        qspi_cs   = 1'b1;
        qspi_dq_i = 4'h0;
        mem[32'h10]  = 8'hA5;
        mem[32'h11]  = 8'h3C;
        mem[32'h12]  = 8'hFF;
        mem[32'h13]  = 8'h00;
        mem[32'hFF]  = 8'h9E;
        mem[32'h100] = 8'h12;
        lit_rd = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        lit_id = '{8'hEF, 8'h40, 8'h18, 8'hEF};
        lit_nb = '{4'h9, 4'hE, 4'h1, 4'h2};
        repeat (3) @(negedge clk);
        check("reset dq_o", 32'(qspi_dq_o), 32'(0));
        check("reset dq_oe", 32'(qspi_dq_oe), 32'(0));
        check("reset mem_req", 32'(mem_req), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset cmd_err", 32'(cmd_err), 32'(0));
        globalrst = 1'b0;
        repeat (6) @(negedge clk);

        xfer(8'h03, 24'h000010, 32, -1);
        for (int k = 0; k < 4; k++) begin
            check("read byte literal", 32'(rx_byte(k)), 32'(lit_rd[k]));
            check("read addr literal", 32'(seen_q[k]), 32'h10 + 32'(k));
        end
        check("read req count", 32'(seen_q.size()), 32'(5));

        xfer(8'h6B, 24'h0000FF, 4, -1);
        for (int k = 0; k < 4; k++) check("quad nibble literal", 32'(rx_q[k]), 32'(lit_nb[k]));
        check("quad addr0 literal", 32'(seen_q[0]), 32'h0000FF);
        check("quad addr1 literal", 32'(seen_q[1]), 32'h000100);

        xfer(8'h03, 24'hFFFFFF, 16, -1);
        check("wrap addr0 literal", 32'(seen_q[0]), 32'h00FFFFFF);
        check("wrap addr1 literal", 32'(seen_q[1]), 32'h00000000);
        check("wrap req count", 32'(seen_q.size()), 32'(3));

        xfer(8'h9F, 24'h0, 32, -1);
        for (int k = 0; k < 4; k++) check("id byte literal", 32'(rx_byte(k)), 32'(lit_id[k]));
        check("id no mem_req", 32'(seen_q.size()), 32'(0));

        xfer(8'h5A, 24'h0, 16, -1);
        check("bad opcode pulses", 32'(err_seen), 32'(1));
        xfer(8'h03, 24'h000012, 16, -1);
        check("read after bad op", 32'(rx_byte(0)), 32'hFF);

        xfer(8'h0B, 24'h001234, 13, -1);
        xfer(8'h9F, 24'h0, 8, -1);
        check("id after abort", 32'(rx_byte(0)), 32'hEF);

        xfer(8'h03, 24'h000040, 0, 12);
        xfer(8'h03, 24'h000010, 8, -1);
        check("read after reset", 32'(rx_byte(0)), 32'hA5);

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 4))
                0: op = 8'h03;
                1: op = 8'h0B;
                2: op = 8'h6B;
                3: op = 8'h9F;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h03 || op == 8'h0B || op == 8'h6B || op == 8'h9F) op = 8'hC7;
                end
            endcase
            ra = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'hFFFFF8 + 24'($urandom_range(0, 7));
            xfer(op, ra, $urandom_range(1, 40), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
